// File: rtl/tri_fifo_arbiter.sv
// tri_fifo_arbiter
//   Write-side arbiter for the triangle FIFO feeding the line stepper.
//   Merges new triangles from precalc (valid/ready) with triangles
//   recirculated by the line stepper (push-only, buffered locally).
//   Each triangle is an atomic two-word pair (header, slope); pairs are
//   never interleaved and recirculated pairs win arbitration.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   pc_wrdata    precalc word
//   pc_valid     precalc word valid
//   pc_ready     precalc word accepted when pc_valid & pc_ready
//   rc_wrdata    recirculated word
//   rc_push      recirculated word strobe (two consecutive cycles per pair)
//   fifo_wrdata  registered word to the triangle FIFO
//   fifo_push    registered FIFO write strobe
//   fifo_afull   FIFO has fewer than 2 free entries
//   rc_overflow  sticky: recirculated word dropped on a full buffer
//   tri_count    triangles written to the FIFO, wrapping
module tri_fifo_arbiter #(
  parameter int WIDTH    = 240,
  parameter int RC_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_wrdata,
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic [WIDTH-1:0] rc_wrdata,
  input  logic             rc_push,
  output logic [WIDTH-1:0] fifo_wrdata,
  output logic             fifo_push,
  input  logic             fifo_afull,
  output logic             rc_overflow,
  output logic [15:0]      tri_count
);

  localparam int AW = $clog2(RC_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(RC_DEPTH);
  localparam logic [AW:0] LVL_PAIR = (AW+1)'(2);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RC1  = 3'd1;
  localparam logic [2:0] S_RC2  = 3'd2;
  localparam logic [2:0] S_PC1  = 3'd3;
  localparam logic [2:0] S_PC2  = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] rc_mem [RC_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             pair_half;
  logic             rc_full;
  logic             rc_wr;
  logic             rc_rd;
  logic             rc_pair;

  always_comb begin
    rc_full  = (level == LVL_FULL);
    rc_wr    = rc_push & ~rc_full;
    rc_rd    = (state == S_RC1) | (state == S_RC2);
    // pair_half tracks every strobe (dropped or not) so a half-received
    // pair is never granted even while an older complete pair is queued.
    rc_pair  = (level >= LVL_PAIR) & ~pair_half;
    pc_ready = (state == S_PC1) | (state == S_PC2);
  end

  // Buffer storage carries no reset; validity lives in pointers and level.
  always_ff @(posedge clk) begin
    if (rc_wr) begin
      rc_mem[wr_ptr] <= rc_wrdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      pair_half   <= 1'b0;
      rc_overflow <= 1'b0;
    end else begin
      if (rc_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rc_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (rc_push) begin
        pair_half <= ~pair_half;
      end
      if (rc_push && rc_full) begin
        rc_overflow <= 1'b1;
      end
      case ({rc_wr, rc_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      fifo_push   <= 1'b0;
      fifo_wrdata <= '0;
      tri_count   <= '0;
    end else begin
      fifo_push <= 1'b0;
      case (state)
        S_IDLE: begin
          // Both FIFO entries are reserved here; afull is not rechecked mid-pair.
          if (!fifo_afull) begin
            if (rc_pair) begin
              state <= S_RC1;
            end else if (pc_valid) begin
              state <= S_PC1;
            end
          end
        end
        S_RC1: begin
          fifo_push   <= 1'b1;
          fifo_wrdata <= rc_mem[rd_ptr];
          state       <= S_RC2;
        end
        S_RC2: begin
          fifo_push   <= 1'b1;
          fifo_wrdata <= rc_mem[rd_ptr];
          tri_count   <= tri_count + 1'b1;
          state       <= S_IDLE;
        end
        S_PC1: begin
          if (pc_valid) begin
            fifo_push   <= 1'b1;
            fifo_wrdata <= pc_wrdata;
            state       <= S_PC2;
          end
        end
        S_PC2: begin
          if (pc_valid) begin
            fifo_push   <= 1'b1;
            fifo_wrdata <= pc_wrdata;
            tri_count   <= tri_count + 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_fifo_arbiter.sv
// tb_tri_fifo_arbiter
//   Directed self-checking bench for tri_fifo_arbiter. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
module tb_tri_fifo_arbiter;

  localparam int W = 240;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] pc_wrdata = '0;
  logic         pc_valid = 1'b0;
  logic         pc_ready;
  logic [W-1:0] rc_wrdata = '0;
  logic         rc_push = 1'b0;
  logic [W-1:0] fifo_wrdata;
  logic         fifo_push;
  logic         fifo_afull = 1'b0;
  logic         rc_overflow;
  logic [15:0]  tri_count;

  int checks   = 0;
  int failures = 0;

  tri_fifo_arbiter #(.WIDTH(W), .RC_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_wrdata   (pc_wrdata),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .rc_wrdata   (rc_wrdata),
    .rc_push     (rc_push),
    .fifo_wrdata (fifo_wrdata),
    .fifo_push   (fifo_push),
    .fifo_afull  (fifo_afull),
    .rc_overflow (rc_overflow),
    .tri_count   (tri_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [29:0] n);
    return {n, ~n, n, ~n, n, ~n, n, ~n};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_valid = 1'b1; pc_wrdata = mk(30'd1);
    step(); step();
    checks++; if (fifo_push !== 1'b0) begin $display("FAIL reset_push got=%b exp=0", fifo_push); failures++; end
    checks++; if (fifo_wrdata !== '0) begin $display("FAIL reset_wrdata got=%h exp=0", fifo_wrdata); failures++; end
    checks++; if (pc_ready !== 1'b0) begin $display("FAIL reset_pc_ready got=%b exp=0", pc_ready); failures++; end
    checks++; if (rc_overflow !== 1'b0) begin $display("FAIL reset_overflow got=%b exp=0", rc_overflow); failures++; end
    checks++; if (tri_count !== 16'd0) begin $display("FAIL reset_tri_count got=%0d exp=0", tri_count); failures++; end
    rst = 1'b1;
    step();
    checks++; if (pc_ready !== 1'b1) begin $display("FAIL pc1_ready got=%b exp=1", pc_ready); failures++; end
    checks++; if (fifo_push !== 1'b0) begin $display("FAIL pc1_push got=%b exp=0", fifo_push); failures++; end
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd1)}) begin $display("FAIL pc_word_a got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd1)); failures++; end
    pc_wrdata = mk(30'd2);
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd2)}) begin $display("FAIL pc_word_b got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd2)); failures++; end
    checks++; if (tri_count !== 16'd1) begin $display("FAIL pc_tri_count got=%0d exp=1", tri_count); failures++; end
    checks++; if (pc_ready !== 1'b0) begin $display("FAIL pc_idle_ready got=%b exp=0", pc_ready); failures++; end
    pc_valid = 1'b0;
  endtask

  task automatic test_rc_pair();
    logic         ep;
    logic [W-1:0] ed;
    for (int k = 0; k < 6; k++) begin
      rc_push   = (k < 2);
      rc_wrdata = mk(30'(10 + k));
      step();
      ep = (k == 3) || (k == 4);
      ed = (k == 3) ? mk(30'd10) : mk(30'd11);
      checks++; if (fifo_push !== ep) begin $display("FAIL rc_push_cycle%0d got=%b exp=%b", k, fifo_push, ep); failures++; end
      if (ep) begin
        checks++; if (fifo_wrdata !== ed) begin $display("FAIL rc_data_cycle%0d got=%h exp=%h", k, fifo_wrdata, ed); failures++; end
      end
      checks++; if (pc_ready !== 1'b0) begin $display("FAIL rc_pc_ready_cycle%0d got=%b exp=0", k, pc_ready); failures++; end
    end
    checks++; if (tri_count !== 16'd2) begin $display("FAIL rc_tri_count got=%0d exp=2", tri_count); failures++; end
  endtask

  task automatic test_simultaneous();
    rc_push = 1'b1; rc_wrdata = mk(30'd20);
    step();
    rc_wrdata = mk(30'd21);
    step();
    rc_push = 1'b0; pc_valid = 1'b1; pc_wrdata = mk(30'd30);
    step();
    checks++; if ({fifo_push, pc_ready} !== 2'b00) begin $display("FAIL sim_rc1 got=%b%b exp=00", fifo_push, pc_ready); failures++; end
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd20)}) begin $display("FAIL sim_r0 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd20)); failures++; end
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd21)}) begin $display("FAIL sim_r1 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd21)); failures++; end
    checks++; if (pc_ready !== 1'b0) begin $display("FAIL sim_ready_rc got=%b exp=0", pc_ready); failures++; end
    step();
    checks++; if ({fifo_push, pc_ready} !== 2'b01) begin $display("FAIL sim_pc1 got=%b%b exp=01", fifo_push, pc_ready); failures++; end
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd30)}) begin $display("FAIL sim_p0 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd30)); failures++; end
    pc_wrdata = mk(30'd31);
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd31)}) begin $display("FAIL sim_p1 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd31)); failures++; end
    checks++; if (tri_count !== 16'd4) begin $display("FAIL sim_tri_count got=%0d exp=4", tri_count); failures++; end
    pc_valid = 1'b0;
  endtask

  task automatic test_pc2_hold();
    pc_valid = 1'b1; pc_wrdata = mk(30'd40);
    step();
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd40)}) begin $display("FAIL hold_p0 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd40)); failures++; end
    pc_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rc_push   = (k < 2);
      rc_wrdata = mk(30'(50 + k));
      step();
      checks++; if ({fifo_push, pc_ready} !== 2'b01) begin $display("FAIL hold_wait%0d got=%b%b exp=01", k, fifo_push, pc_ready); failures++; end
    end
    rc_push = 1'b0; pc_valid = 1'b1; pc_wrdata = mk(30'd41);
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd41)}) begin $display("FAIL hold_p1 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd41)); failures++; end
    pc_valid = 1'b0;
    step();
    checks++; if (fifo_push !== 1'b0) begin $display("FAIL hold_rc1 got=%b exp=0", fifo_push); failures++; end
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd50)}) begin $display("FAIL hold_r0 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd50)); failures++; end
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd51)}) begin $display("FAIL hold_r1 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd51)); failures++; end
    step();
    checks++; if (fifo_push !== 1'b0) begin $display("FAIL hold_after got=%b exp=0", fifo_push); failures++; end
    checks++; if (tri_count !== 16'd6) begin $display("FAIL hold_tri_count got=%0d exp=6", tri_count); failures++; end
    checks++; if (rc_overflow !== 1'b0) begin $display("FAIL hold_overflow got=%b exp=0", rc_overflow); failures++; end
  endtask

  task automatic test_afull();
    logic [5:0] exp_push;
    logic [W-1:0] exp_data [6];
    fifo_afull = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rc_push   = (k < 6);
      rc_wrdata = mk(30'(100 + k));
      step();
      checks++; if (fifo_push !== 1'b0) begin $display("FAIL afull_push_cycle%0d got=%b exp=0", k, fifo_push); failures++; end
      if (k == 3) begin
        checks++; if (rc_overflow !== 1'b0) begin $display("FAIL afull_no_overflow got=%b exp=0", rc_overflow); failures++; end
      end
      if (k == 4) begin
        checks++; if (rc_overflow !== 1'b1) begin $display("FAIL afull_overflow got=%b exp=1", rc_overflow); failures++; end
      end
    end
    rc_push = 1'b0; fifo_afull = 1'b0;
    exp_push = 6'b011011;
    exp_data = '{mk(30'd0), mk(30'd100), mk(30'd101), mk(30'd0), mk(30'd102), mk(30'd103)};
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (fifo_push !== exp_push[5-k]) begin $display("FAIL drain_push_cycle%0d got=%b exp=%b", k, fifo_push, exp_push[5-k]); failures++; end
      if (exp_push[5-k]) begin
        checks++; if (fifo_wrdata !== exp_data[k]) begin $display("FAIL drain_data_cycle%0d got=%h exp=%h", k, fifo_wrdata, exp_data[k]); failures++; end
      end
    end
    step();
    checks++; if (fifo_push !== 1'b0) begin $display("FAIL drain_end got=%b exp=0", fifo_push); failures++; end
    checks++; if (tri_count !== 16'd8) begin $display("FAIL drain_tri_count got=%0d exp=8", tri_count); failures++; end
    checks++; if (rc_overflow !== 1'b1) begin $display("FAIL overflow_sticky got=%b exp=1", rc_overflow); failures++; end
  endtask

  task automatic test_reset_mid_pair();
    pc_valid = 1'b1; pc_wrdata = mk(30'd200);
    step();
    rc_push = 1'b1; rc_wrdata = mk(30'd300);
    step();
    rc_push = 1'b0; pc_valid = 1'b0;
    checks++; if ({fifo_push, pc_ready} !== 2'b11) begin $display("FAIL midrst_pc2 got=%b%b exp=11", fifo_push, pc_ready); failures++; end
    rst = 1'b0;
    #1;
    checks++; if (fifo_push !== 1'b0) begin $display("FAIL midrst_push got=%b exp=0", fifo_push); failures++; end
    checks++; if (fifo_wrdata !== '0) begin $display("FAIL midrst_wrdata got=%h exp=0", fifo_wrdata); failures++; end
    checks++; if (pc_ready !== 1'b0) begin $display("FAIL midrst_ready got=%b exp=0", pc_ready); failures++; end
    checks++; if (rc_overflow !== 1'b0) begin $display("FAIL midrst_overflow got=%b exp=0", rc_overflow); failures++; end
    checks++; if (tri_count !== 16'd0) begin $display("FAIL midrst_tri_count got=%0d exp=0", tri_count); failures++; end
    step();
    rst = 1'b1;
    rc_push = 1'b1; rc_wrdata = mk(30'd301);
    step();
    rc_wrdata = mk(30'd302);
    step();
    rc_push = 1'b0;
    step();
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd301)}) begin $display("FAIL post_rst_r0 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd301)); failures++; end
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd302)}) begin $display("FAIL post_rst_r1 got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd302)); failures++; end
    checks++; if (tri_count !== 16'd1) begin $display("FAIL post_rst_tri_count got=%0d exp=1", tri_count); failures++; end
  endtask

  task automatic test_tri_wrap();
    force dut.tri_count = 16'hFFFF;
    #1;
    release dut.tri_count;
    #1;
    checks++; if (tri_count !== 16'hFFFF) begin $display("FAIL wrap_preset got=%h exp=ffff", tri_count); failures++; end
    pc_valid = 1'b1; pc_wrdata = mk(30'd400);
    step();
    step();
    checks++; if (tri_count !== 16'hFFFF) begin $display("FAIL wrap_mid got=%h exp=ffff", tri_count); failures++; end
    pc_wrdata = mk(30'd401);
    step();
    checks++; if ({fifo_push, fifo_wrdata} !== {1'b1, mk(30'd401)}) begin $display("FAIL wrap_word got=%b/%h exp=1/%h", fifo_push, fifo_wrdata, mk(30'd401)); failures++; end
    checks++; if (tri_count !== 16'h0000) begin $display("FAIL wrap_tri_count got=%h exp=0000", tri_count); failures++; end
    pc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rc_pair();
    test_simultaneous();
    test_pc2_hold();
    test_afull();
    test_reset_mid_pair();
    test_tri_wrap();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_fifo_arbiter.md
# tri_fifo_arbiter

Write-side arbiter for the triangle FIFO that feeds the line stepper. It merges two producers into the single 240-bit FIFO write port. The producers are new triangles from precalc (valid/ready) and triangles recirculated by the line stepper at frameblock boundaries (push-only, no backpressure). Every triangle is an atomic pair of consecutive words (header word, then slope word). The arbiter never interleaves words of different triangles, gives recirculated triangles priority, and buffers them so none are lost while the FIFO is busy.

## Interface
- WIDTH, 240, triangle word width in bits.
- RC_DEPTH, 4, recirculation buffer depth in words; power of two, minimum 4.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous and active-low.
- pc_wrdata  in  WIDTH  precalc word.
- pc_valid  in  1  precalc word valid; producer presents header then slope.
- pc_ready  out  1  precalc word accepted when pc_valid & pc_ready.
- rc_wrdata  in  WIDTH  recirculated word from the line stepper.
- rc_push  in  1  recirculated word strobe; always two consecutive cycles per triangle.
- fifo_wrdata  out  WIDTH  registered word to the triangle FIFO.
- fifo_push  out  1  registered write strobe.
- fifo_afull  in  1  FIFO has fewer than 2 free entries.
- rc_overflow  out  1  sticky: rc_push arrived with the buffer full.
- tri_count  out  16  count of triangles written to the FIFO; wraps at 16'hFFFF -> 0.

## Operation
- Recirculation buffer: circular, RC_DEPTH words, write pointer, read pointer, level counter of log2(RC_DEPTH)+1 bits.
  - Every rc_push writes one word unless the buffer is full.
  - A push with the buffer full drops the word and sets rc_overflow.
  - A simultaneous read and write in one cycle leaves the level unchanged.
- rc_pair: level >= 2 and the buffer is not in the middle of receiving a pair. A word counter toggles on each rc_push, so a half-written pair is never granted.
- States: IDLE, RC1, RC2, PC1, PC2.
- IDLE:
  - If fifo_afull, stay in IDLE.
  - Else if rc_pair, go to RC1.
  - Else if pc_valid, go to PC1.
  - Else stay in IDLE.
  - A pair is started only if the FIFO can take both words.
- RC1 / RC2: each state pops one buffer word to fifo_wrdata with fifo_push=1. RC1 -> RC2 -> IDLE unconditionally.
- PC1: pc_ready=1.
  - On pc_valid, register the word, push it, and go to PC2.
  - Otherwise wait in PC1.
- PC2: pc_ready=1.
  - On pc_valid, push the word, increment tri_count, and go to IDLE.
  - Otherwise wait in PC2. Precalc must not stall mid-pair for long, because recirculation pairs wait behind it.
- tri_count increments on the second word of a pair, in RC2 or on the PC2 accept.
- pc_ready=0 in IDLE, RC1 and RC2.
- Priority is strict recirculation-first. No starvation occurs because the line stepper recirculates at most one pair per 6 cycles.
- Word contents pass through unmodified.

## Timing
- Reset values:
  - state = IDLE; pointers, level and pair counter = 0.
  - fifo_push = 0, fifo_wrdata = 0, pc_ready = 0, rc_overflow = 0, tri_count = 0.
- Reset mid-pair: a partial pair is abandoned, and the buffer contents are discarded.
- Latency from precalc: a word accepted in cycle N appears with fifo_push=1 in cycle N+1.
- Latency from recirculation: the second rc_push word is in cycle N, rc_pair is seen in N+1 (IDLE), RC1 is in N+2, and the words are on the FIFO port in N+3 and N+4.
- A best-case pair takes 3 cycles (IDLE, W1, W2). Throughput is 2 words per 3 cycles.
- fifo_afull is sampled only in IDLE. It is ignored inside a pair, since the pair's 2 entries were reserved at the start.
- rc_overflow clears only on reset.

## Test plan
- Reset release with pc_valid=1 and two precalc words A, B: pc_ready rises in PC1; fifo_push=1 with A, then with B; tri_count becomes 1.
- rc_push of R0, R1 while idle: R0 and R1 appear on fifo_wrdata 3 and 4 cycles after R1; pc_ready stays 0 throughout.
- Simultaneous arrival (rc pair complete and pc_valid=1 in the same cycle): both R words are written before either P word, and no interleaving occurs; tri_count advances by 2.
- rc_push of a pair while the arbiter sits in PC2 with pc_valid=0 for 5 cycles: the rc pair is held, then written right after the P pair completes; rc_overflow stays 0.
- fifo_afull=1 held for 20 cycles while two rc pairs arrive: no fifo_push occurs. A third rc pair overflows the depth-4 buffer and rc_overflow=1. After fifo_afull drops, the first two pairs drain in order.
- tri_count preset by driving 65535 pairs (or forced) plus one more: the counter wraps to 0. Asserting rst mid-PC2 makes all outputs return to their reset values in the same cycle.
